// File: rtl/timer_responder.sv
// timer_responder: memory-mapped down-counter (CTRL/PRESET/COUNT) raising a maskable
// interrupt request, one-shot or auto-reload.
module timer_responder #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
  state_t             state_q, state_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d, count_q, count_d;
  logic               flag_q, flag_d;
  logic               reload;
  assign reload = ctrl_q[2:1] == 2'b01;
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: state_d = ctrl_q[0] ? S_LOAD : S_IDLE;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) state_d = S_IDLE;
        else if (count_q > CNT_W'(1)) count_d = count_q - CNT_W'(1);
        else begin
          // flag rises on entry so irq is visible while in INT
          count_d = '0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      default: begin
        if (reload) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase
    // bus writes override any FSM update of CTRL and irq_flag
    if (we && addr == 2'd0) begin
      ctrl_d = wdata[3:0];
      flag_d = 1'b0;
    end
    if (we && addr == 2'd1) preset_d = wdata[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end
  assign rdata = addr == 2'd0 ? {28'b0, ctrl_q} :
                 addr == 2'd1 ? 32'(preset_q) :
                 addr == 2'd2 ? 32'(count_q) : 32'b0;
  assign irq = ctrl_q[3] & flag_q;
endmodule

// File: tb/tb_timer_responder.sv
// tb_timer_responder: directed checks of the timer: reset, one-shot, auto-reload,
// masking, stop, corner writes and asynchronous reset.
module tb_timer_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  int          errors = 0;
  int          checks = 0;
  timer_responder #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 2'd2;
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = 2'd2;
  endtask
  initial begin
    reset = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rd("rst_ctrl", 2'd0, 0);
    rd("rst_preset", 2'd1, 0);
    rd("rst_count", 2'd2, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    rd("idle_count", 2'd2, 0);
    chk("idle_irq", {31'b0, irq}, 0);
    // one-shot, PRESET=5: COUNT 0,5,4,3,2,1,0 after E1..E7, irq from E7
    wr(2'd1, 5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick();
      rd("os_count", 2'd2, k < 2 ? 0 : 7 - k);
      chk("os_irq", {31'b0, irq}, k == 7 ? 1 : 0);
    end
    tick();
    rd("os_ctrl_en_clr", 2'd0, 32'h8);
    chk("os_irq_sticky", {31'b0, irq}, 1);
    tick();
    tick();
    chk("os_irq_sticky2", {31'b0, irq}, 1);
    wr(2'd0, 0);
    chk("os_irq_drop", {31'b0, irq}, 0);
    // auto-reload, PRESET=3: INT at E5, E10, E15, E20
    wr(2'd1, 3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk("ar_irq", {31'b0, irq}, (k >= 5 && (k % 5) == 0) ? 1 : 0);
    end
    rd("ar_ctrl", 2'd0, 32'hB);
    wr(2'd0, 0);
    for (int k = 0; k < 6; k++) tick();
    chk("ar_stop_irq", {31'b0, irq}, 0);
    // masked one-shot, PRESET=2: INT at E4, no irq
    wr(2'd1, 2);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mask_irq", {31'b0, irq}, 0);
    end
    rd("mask_count", 2'd2, 0);
    rd("mask_ctrl", 2'd0, 0);
    // stop at 6: EN clear lands at E6 (count 7->6), freeze from E7
    wr(2'd1, 10);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    rd("stop_pre", 2'd2, 7);
    wr(2'd0, 0);
    rd("stop_at", 2'd2, 6);
    for (int k = 0; k < 5; k++) tick();
    rd("stop_frozen", 2'd2, 6);
    chk("stop_irq", {31'b0, irq}, 0);
    // PRESET=0 acts as 1: INT at E3
    wr(2'd1, 0);
    wr(2'd0, 32'h9);
    tick();
    chk("p0_irq_e1", {31'b0, irq}, 0);
    tick();
    chk("p0_irq_e2", {31'b0, irq}, 0);
    rd("p0_count_e2", 2'd2, 0);
    tick();
    chk("p0_irq_e3", {31'b0, irq}, 1);
    wr(2'd0, 0);
    chk("p0_irq_clr", {31'b0, irq}, 0);
    // PRESET rewrite and COUNT write mid-count leave the countdown alone
    wr(2'd1, 5);
    wr(2'd0, 32'h1);
    tick();
    tick();
    tick();
    wr(2'd1, 9);
    rd("mid_preset_cnt", 2'd2, 3);
    tick();
    rd("mid_preset_cnt2", 2'd2, 2);
    wr(2'd2, 32'h55);
    rd("cnt_write_ign", 2'd2, 1);
    tick();
    rd("mid_zero", 2'd2, 0);
    tick();
    wr(2'd0, 32'h1);
    tick();
    tick();
    rd("new_preset_load", 2'd2, 9);
    rd("preset_rd", 2'd1, 9);
    rd("addr3_zero", 2'd3, 0);
    tick();
    rd("pre_areset", 2'd2, 8);
    // async reset between edges
    #3;
    reset = 1'b0;
    #1;
    chk("ar_count", rdata, 0);
    addr = 2'd0;
    #1;
    chk("ar_ctrl_zero", rdata, 0);
    chk("ar_irq_zero", {31'b0, irq}, 0);
    addr = 2'd2;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rd("post_rst_count", 2'd2, 0);
    rd("post_rst_ctrl", 2'd0, 0);
    rd("post_rst_preset", 2'd1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
